// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-master arbiter in front of the shared single-port data memory
// Round-robin or fixed-priority selection with a hold limit; same-cycle writes, registered read return.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_HOLD  = 4,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]        owner_q, owner_d;
  logic              last_q, last_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;
  logic              m0_rvalid_q, m1_rvalid_q;

  logic gnt0, gnt1, hold_ok, at_max, same_owner;

  // Grants are masked by rst so they fall the moment reset asserts, independent of the clock.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    hold_ok = (hold_q < HOLD_MAX);
    at_max  = (hold_q == HOLD_MAX);
    if (!rst) begin
      if (m0_req && !m1_req) begin
        gnt0 = 1'b1;
      end else if (m1_req && !m0_req) begin
        gnt1 = 1'b1;
      end else if (m0_req && m1_req) begin
        if (owner_q == OWN0 && hold_ok) begin
          gnt0 = 1'b1;
        end else if (owner_q == OWN1 && hold_ok && PRIO_MODE == 0) begin
          gnt1 = 1'b1;
        end else if (PRIO_MODE == 0) begin
          gnt0 = last_q;
          gnt1 = !last_q;
        end else if (owner_q == OWN0 && at_max) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = 1'b1;
        end
      end
    end
  end

  always_comb begin
    owner_d    = IDLE;
    last_d     = last_q;
    hold_d     = '0;
    same_owner = (gnt0 && owner_q == OWN0) || (gnt1 && owner_q == OWN1);
    if (gnt0 || gnt1) begin
      owner_d = gnt1 ? OWN1 : OWN0;
      last_d  = gnt1;
      if (!same_owner) begin
        hold_d = HW'(1);
      end else if (at_max) begin
        hold_d = hold_q;
      end else begin
        hold_d = hold_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_rdata_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rdata_q  <= '0;
      m1_rvalid_q <= 1'b0;
    end else begin
      m0_rvalid_q <= gnt0 && !m0_we;
      m1_rvalid_q <= gnt1 && !m1_we;
      if (gnt0 && !m0_we) m0_rdata_q <= mem_read_data;
      if (gnt1 && !m1_we) m1_rdata_q <= mem_read_data;
    end
  end

  assign m0_gnt         = gnt0;
  assign m1_gnt         = gnt1;
  assign mem_address    = gnt1 ? m1_addr : m0_addr;
  assign mem_write_data = gnt1 ? m1_wdata : m0_wdata;
  assign mem_write      = (gnt0 && m0_we) || (gnt1 && m1_we);
  assign m0_rdata       = m0_rdata_q;
  assign m0_rvalid      = m0_rvalid_q;
  assign m1_rdata       = m1_rdata_q;
  assign m1_rvalid      = m1_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_write;
  logic [31:0] m0_rdata, m1_rdata, mem_address, mem_write_data, mem_read_data;

  logic        p_m0_gnt, p_m0_rvalid, p_m1_gnt, p_m1_rvalid, p_mem_write;
  logic [31:0] p_m0_rdata, p_m1_rdata, p_mem_address, p_mem_write_data;
  logic [31:0] p_mem_read_data = 32'h0;

  logic [31:0] mem [32];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4), .PRIO_MODE(0)) dut_rr (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read_data(mem_read_data)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4), .PRIO_MODE(1)) dut_pr (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(p_m0_gnt), .m0_rdata(p_m0_rdata), .m0_rvalid(p_m0_rvalid),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(p_m1_gnt), .m1_rdata(p_m1_rdata), .m1_rvalid(p_m1_rvalid),
    .mem_address(p_mem_address), .mem_write_data(p_mem_write_data),
    .mem_write(p_mem_write), .mem_read_data(p_mem_read_data)
  );

  // 32-word memory: combinational read, posedge write
  assign mem_read_data = mem[mem_address[4:0]];
  always @(posedge clk) if (mem_write) mem[mem_address[4:0]] <= mem_write_data;

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic apply_reset();
    rst = 1; idle_inputs();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    m0_req = 1; m1_req = 1;
    #1;
    n_checks++; if (m0_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_m0_gnt: got %b want 0", m0_gnt); end
    n_checks++; if (m1_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_m1_gnt: got %b want 0", m1_gnt); end
    n_checks++; if (p_m0_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_p_m0_gnt: got %b want 0", p_m0_gnt); end
    n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL rst_mem_write: got %b want 0", mem_write); end
    @(posedge clk); #1;
    n_checks++; if (m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m0_rvalid: got %b want 0", m0_rvalid); end
    n_checks++; if (m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_m1_rvalid: got %b want 0", m1_rvalid); end
    n_checks++; if (m0_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_m0_rdata: got %h want 0", m0_rdata); end
    n_checks++; if (m1_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_m1_rdata: got %h want 0", m1_rdata); end
  endtask

  task automatic test_write_read();
    apply_reset();
    m0_req = 1; m0_we = 1; m0_addr = 3; m0_wdata = 32'hDEADBEEF;
    #1;
    n_checks++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_m0_gnt: got %b want 1", m0_gnt); end
    n_checks++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL wr_mem_write: got %b want 1", mem_write); end
    n_checks++; if (mem_address !== 32'd3) begin n_fail++; $display("FAIL wr_mem_address: got %h want 3", mem_address); end
    n_checks++; if (mem_write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_mem_wdata: got %h want deadbeef", mem_write_data); end
    @(negedge clk);
    m0_we = 0; m0_wdata = 0;
    #1;
    n_checks++; if (m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid: got %b want 0", m0_rvalid); end
    n_checks++; if (m0_gnt !== 1'b1 || mem_write !== 1'b0) begin n_fail++; $display("FAIL rd_gnt_nowrite: got gnt=%b we=%b want 1/0", m0_gnt, mem_write); end
    @(negedge clk);
    m0_req = 0;
    #1;
    n_checks++; if (m0_rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_m0_rvalid: got %b want 1", m0_rvalid); end
    n_checks++; if (m0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_m0_rdata: got %h want deadbeef", m0_rdata); end
    n_checks++; if (m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_m1_rvalid: got %b want 0", m1_rvalid); end
    @(negedge clk); #1;
    n_checks++; if (m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_pulse_end: got %b want 0", m0_rvalid); end
  endtask

  task automatic test_arbitration();
    int rr [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    int pr [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    apply_reset();
    m0_req = 1; m0_addr = 1; m1_req = 1; m1_addr = 2;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++; if (m0_gnt !== (rr[i] == 0) || m1_gnt !== (rr[i] == 1)) begin n_fail++; $display("FAIL rr_seq[%0d]: got %b%b want m%0d", i, m0_gnt, m1_gnt, rr[i]); end
      n_checks++; if (p_m0_gnt !== (pr[i] == 0) || p_m1_gnt !== (pr[i] == 1)) begin n_fail++; $display("FAIL prio_seq[%0d]: got %b%b want m%0d", i, p_m0_gnt, p_m1_gnt, pr[i]); end
      if (i > 0) begin
        n_checks++; if (m0_rvalid !== (rr[i-1] == 0) || m1_rvalid !== (rr[i-1] == 1)) begin n_fail++; $display("FAIL rr_rvalid[%0d]: got %b%b want m%0d", i, m0_rvalid, m1_rvalid, rr[i-1]); end
      end
      @(negedge clk);
    end
    m0_req = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (p_m1_gnt !== 1'b1 || p_m0_gnt !== 1'b0) begin n_fail++; $display("FAIL prio_m1_alone[%0d]: got %b%b want 01", i, p_m0_gnt, p_m1_gnt); end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_tie_write_then_read();
    apply_reset();
    m0_req = 1; m0_addr = 0;
    #1;
    n_checks++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL tie_first_m0: got %b want 1", m0_gnt); end
    @(negedge clk);
    m0_req = 0;
    @(negedge clk);
    m0_req = 1; m0_we = 0; m0_addr = 7;
    m1_req = 1; m1_we = 1; m1_addr = 7; m1_wdata = 32'h12345678;
    #1;
    n_checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin n_fail++; $display("FAIL tie_last0_m1: got %b%b want 01", m0_gnt, m1_gnt); end
    n_checks++; if (mem_write !== 1'b1 || mem_write_data !== 32'h12345678) begin n_fail++; $display("FAIL tie_m1_write: got we=%b d=%h want 1/12345678", mem_write, mem_write_data); end
    @(negedge clk);
    m1_req = 0; m1_we = 0;
    #1;
    n_checks++; if (m0_gnt !== 1'b1 || mem_address !== 32'd7) begin n_fail++; $display("FAIL raw_m0_gnt: got gnt=%b a=%h want 1/7", m0_gnt, mem_address); end
    @(negedge clk);
    m0_req = 0;
    #1;
    n_checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h12345678) begin n_fail++; $display("FAIL raw_m0_rdata: got v=%b d=%h want 1/12345678", m0_rvalid, m0_rdata); end
    n_checks++; if (m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL raw_m1_rvalid: got %b want 0", m1_rvalid); end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    apply_reset();
    m1_req = 1; m1_we = 0; m1_addr = 9;
    #1;
    n_checks++; if (m1_gnt !== 1'b1) begin n_fail++; $display("FAIL ar_pre_gnt: got %b want 1", m1_gnt); end
    #2 rst = 1;
    #1;
    n_checks++; if (m1_gnt !== 1'b0 || mem_write !== 1'b0) begin n_fail++; $display("FAIL ar_gnt_drop: got gnt=%b we=%b want 0/0", m1_gnt, mem_write); end
    @(posedge clk); #1;
    n_checks++; if (m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL ar_no_rvalid: got %b want 0", m1_rvalid); end
    @(negedge clk);
    idle_inputs(); rst = 0;
    #1;
    n_checks++; if (m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL ar_no_rvalid_after: got %b want 0", m1_rvalid); end
    m0_req = 1; m1_req = 1;
    #1;
    n_checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL ar_first_tie: got %b%b want 10", m0_gnt, m1_gnt); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_req_drop();
    apply_reset();
    m1_req = 1; m1_we = 0; m1_addr = 4;
    #1;
    n_checks++; if (m1_gnt !== 1'b1) begin n_fail++; $display("FAIL drop_m1_gnt: got %b want 1", m1_gnt); end
    @(negedge clk);
    m0_req = 1; m0_we = 1; m0_addr = 5; m0_wdata = 32'hAAAA5555;
    #1;
    n_checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b1 || mem_write !== 1'b0) begin n_fail++; $display("FAIL drop_hold: got g0=%b g1=%b we=%b want 0/1/0", m0_gnt, m1_gnt, mem_write); end
    @(negedge clk);
    m0_req = 0;
    #1;
    n_checks++; if (m0_gnt !== 1'b0 || mem_write !== 1'b0 || m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL drop_after: got g0=%b we=%b v0=%b want 0/0/0", m0_gnt, mem_write, m0_rvalid); end
    @(negedge clk);
    m1_req = 0;
    @(negedge clk); #1;
    n_checks++; if (m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL drop_m0_rvalid: got %b want 0", m0_rvalid); end
    n_checks++; if (mem[5] !== 32'h0) begin n_fail++; $display("FAIL drop_mem5: got %h want 0", mem[5]); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    test_reset();
    test_write_read();
    test_arbitration();
    test_tie_write_then_read();
    test_async_reset();
    test_req_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
